// File: rtl/core_pkg.sv
// core_pkg: shared writeback constants and types.
//   XLEN      default data width
//   REG_AW    default register address width
//   wb_src_e  writeback source identifier (also the arbiter's last-grant pointer)
//   wb_req_t  writeback request payload
package core_pkg;
    localparam int XLEN   = 32;
    localparam int REG_AW = 5;
    typedef enum logic {WB_ALU, WB_LSU} wb_src_e;
    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_req_t;
endpackage

// File: rtl/core_rr_arb2.sv
// core_rr_arb2: 2-input writeback arbiter, round-robin or fixed ALU priority.
//   clk, rst    clock, async active-high reset
//   req_alu_i   ALU request
//   req_lsu_i   LSU request
//   gnt_alu_o   ALU grant (combinational)
//   gnt_lsu_o   LSU grant (combinational)
module core_rr_arb2 #(
    parameter bit RR_EN = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic req_alu_i,
    input  logic req_lsu_i,
    output logic gnt_alu_o,
    output logic gnt_lsu_o
);
    import core_pkg::*;

    wb_src_e last_q, last_d;

    // On conflict the source not granted last time wins; reset leaves the
    // pointer at ALU so the first conflict goes to the LSU.
    always_comb begin
        gnt_lsu_o = req_lsu_i & (~req_alu_i | (RR_EN && last_q == WB_ALU));
        gnt_alu_o = req_alu_i & ~gnt_lsu_o;
        last_d    = gnt_lsu_o ? WB_LSU : (gnt_alu_o ? WB_ALU : last_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) last_q <= WB_ALU;
        else     last_q <= last_d;
    end
endmodule

// File: rtl/core_rf_wr_arb.sv
// core_rf_wr_arb: shares the register-file write port between ALU and LSU
// writeback and tracks load-pending registers for decode hazard stalls.
//   clk, rst                      clock, async active-high reset
//   alu_wb_val/rd/data, _rdy      ALU writeback handshake
//   lsu_wb_val/rd/data, _rdy      load-return writeback handshake
//   lsu_iss_val/rd, _rdy          load issue (marks rd pending)
//   rf_we/rf_rd/rf_data           registered register-file write port
//   rf_busy                       registered per-register load-pending bits
module core_rf_wr_arb #(
    parameter int  XLEN  = 32,
    parameter int  NREG  = 32,
    parameter bit  RR_EN = 1'b1,
    localparam int RAW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            alu_wb_val,
    input  logic [RAW-1:0]  alu_wb_rd,
    input  logic [XLEN-1:0] alu_wb_data,
    output logic            alu_wb_rdy,
    input  logic            lsu_wb_val,
    input  logic [RAW-1:0]  lsu_wb_rd,
    input  logic [XLEN-1:0] lsu_wb_data,
    output logic            lsu_wb_rdy,
    input  logic            lsu_iss_val,
    input  logic [RAW-1:0]  lsu_iss_rd,
    output logic            lsu_iss_rdy,
    output logic            rf_we,
    output logic [RAW-1:0]  rf_rd,
    output logic [XLEN-1:0] rf_data,
    output logic [NREG-1:0] rf_busy
);
    import core_pkg::*;

    logic            gnt_alu, gnt_lsu;
    wb_src_e         src;
    logic [RAW-1:0]  sel_rd;
    logic [XLEN-1:0] sel_data;
    logic            rf_we_d, rf_we_q;
    logic [RAW-1:0]  rf_rd_d, rf_rd_q;
    logic [XLEN-1:0] rf_data_d, rf_data_q;
    logic [NREG-1:0] busy_d, busy_q, set_v, clr_v;

    core_rr_arb2 #(.RR_EN(RR_EN)) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req_alu_i (alu_wb_val),
        .req_lsu_i (lsu_wb_val),
        .gnt_alu_o (gnt_alu),
        .gnt_lsu_o (gnt_lsu)
    );

    always_comb begin
        src         = gnt_lsu ? WB_LSU : WB_ALU;
        sel_rd      = (src == WB_LSU) ? lsu_wb_rd : alu_wb_rd;
        sel_data    = (src == WB_LSU) ? lsu_wb_data : alu_wb_data;
        // x0 writes still handshake but never reach the register file
        rf_we_d     = (gnt_alu | gnt_lsu) && sel_rd != '0;
        rf_rd_d     = rf_we_d ? sel_rd : rf_rd_q;
        rf_data_d   = rf_we_d ? sel_data : rf_data_q;
        // a reissue to a pending rd is fine when its load returns this cycle
        lsu_iss_rdy = ~busy_q[lsu_iss_rd] | (gnt_lsu && lsu_wb_rd == lsu_iss_rd);
        set_v       = (lsu_iss_val && lsu_iss_rdy) ? NREG'(1) << lsu_iss_rd : '0;
        clr_v       = gnt_lsu ? NREG'(1) << lsu_wb_rd : '0;
        busy_d      = ((busy_q & ~clr_v) | set_v) & ~NREG'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_we_q   <= 1'b0;
            rf_rd_q   <= '0;
            rf_data_q <= '0;
            busy_q    <= '0;
        end else begin
            rf_we_q   <= rf_we_d;
            rf_rd_q   <= rf_rd_d;
            rf_data_q <= rf_data_d;
            busy_q    <= busy_d;
        end
    end

    assign alu_wb_rdy = gnt_alu;
    assign lsu_wb_rdy = gnt_lsu;
    assign rf_we      = rf_we_q;
    assign rf_rd      = rf_rd_q;
    assign rf_data    = rf_data_q;
    assign rf_busy    = busy_q;

`ifndef SYNTHESIS
    // a load return for a register that was never marked pending
    always @(posedge clk) begin
        if (!rst && gnt_lsu && lsu_wb_rd != '0)
            assert (busy_q[lsu_wb_rd]) else $error("load return to non-pending rd %0d", lsu_wb_rd);
    end
`endif
endmodule

// File: tb/tb_core_rf_wr_arb.sv
// tb_core_rf_wr_arb: directed self-checking bench for core_rf_wr_arb.
module tb_core_rf_wr_arb;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        alu_val = 0, lsu_val = 0, iss_val = 0;
    logic [4:0]  alu_rd = 0, lsu_rd = 0, iss_rd = 0;
    logic [31:0] alu_data = 0, lsu_data = 0;
    logic        alu_rdy, lsu_rdy, iss_rdy, rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_data, rf_busy;

    logic        f_alu_val = 0, f_lsu_val = 0;
    logic [4:0]  f_alu_rd = 0, f_lsu_rd = 0;
    logic [31:0] f_alu_data = 0, f_lsu_data = 0;
    logic        f_alu_rdy, f_lsu_rdy, f_iss_rdy, f_rf_we;
    logic [4:0]  f_rf_rd;
    logic [31:0] f_rf_data, f_rf_busy;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    core_rf_wr_arb #(.XLEN(32), .NREG(32), .RR_EN(1'b1)) u_rr (
        .clk(clk), .rst(rst),
        .alu_wb_val(alu_val), .alu_wb_rd(alu_rd), .alu_wb_data(alu_data), .alu_wb_rdy(alu_rdy),
        .lsu_wb_val(lsu_val), .lsu_wb_rd(lsu_rd), .lsu_wb_data(lsu_data), .lsu_wb_rdy(lsu_rdy),
        .lsu_iss_val(iss_val), .lsu_iss_rd(iss_rd), .lsu_iss_rdy(iss_rdy),
        .rf_we(rf_we), .rf_rd(rf_rd), .rf_data(rf_data), .rf_busy(rf_busy)
    );

    core_rf_wr_arb #(.XLEN(32), .NREG(32), .RR_EN(1'b0)) u_fp (
        .clk(clk), .rst(rst),
        .alu_wb_val(f_alu_val), .alu_wb_rd(f_alu_rd), .alu_wb_data(f_alu_data), .alu_wb_rdy(f_alu_rdy),
        .lsu_wb_val(f_lsu_val), .lsu_wb_rd(f_lsu_rd), .lsu_wb_data(f_lsu_data), .lsu_wb_rdy(f_lsu_rdy),
        .lsu_iss_val(1'b0), .lsu_iss_rd(5'd0), .lsu_iss_rdy(f_iss_rdy),
        .rf_we(f_rf_we), .rf_rd(f_rf_rd), .rf_data(f_rf_data), .rf_busy(f_rf_busy)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        step();
        step();
        checks++; if ({rf_we, rf_rd, rf_data, rf_busy} !== 70'd0) begin fails++; $display("FAIL reset_rr: got we=%b rd=%0d data=%h busy=%h, want all 0", rf_we, rf_rd, rf_data, rf_busy); end
        checks++; if ({f_rf_we, f_rf_rd, f_rf_data, f_rf_busy} !== 70'd0) begin fails++; $display("FAIL reset_fp: got we=%b rd=%0d data=%h busy=%h, want all 0", f_rf_we, f_rf_rd, f_rf_data, f_rf_busy); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_alu_only;
        alu_val = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
        #1;
        checks++; if ({alu_rdy, lsu_rdy} !== 2'b10) begin fails++; $display("FAIL alu_only_rdy: got alu=%b lsu=%b, want 1 0", alu_rdy, lsu_rdy); end
        step();
        alu_val = 0;
        checks++; if ({rf_we, rf_rd, rf_data} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin fails++; $display("FAIL alu_only_wr: got we=%b rd=%0d data=%h, want 1 5 deadbeef", rf_we, rf_rd, rf_data); end
        step();
        checks++; if ({rf_we, rf_rd, rf_data} !== {1'b0, 5'd5, 32'hDEADBEEF}) begin fails++; $display("FAIL idle_hold: got we=%b rd=%0d data=%h, want 0 5 deadbeef", rf_we, rf_rd, rf_data); end
    endtask

    task automatic test_scoreboard;
        iss_val = 1; iss_rd = 7;
        #1;
        checks++; if (iss_rdy !== 1'b1) begin fails++; $display("FAIL issue7_rdy: got %b, want 1", iss_rdy); end
        step();
        checks++; if (rf_busy !== 32'h80) begin fails++; $display("FAIL issue7_busy: got %h, want 00000080", rf_busy); end
        checks++; if (iss_rdy !== 1'b0) begin fails++; $display("FAIL waw_block: got iss_rdy=%b, want 0", iss_rdy); end
        step();
        iss_rd = 2;
        #1;
        checks++; if (iss_rdy !== 1'b1) begin fails++; $display("FAIL issue2_rdy: got %b, want 1", iss_rdy); end
        step();
        iss_val = 0;
        checks++; if (rf_busy !== 32'h84) begin fails++; $display("FAIL issue2_busy: got %h, want 00000084", rf_busy); end
        lsu_val = 1; lsu_rd = 7; lsu_data = 32'h77;
        #1;
        checks++; if (lsu_rdy !== 1'b1) begin fails++; $display("FAIL lsu7_rdy: got %b, want 1", lsu_rdy); end
        step();
        lsu_val = 0;
        checks++; if ({rf_we, rf_rd, rf_data, rf_busy} !== {1'b1, 5'd7, 32'h77, 32'h4}) begin fails++; $display("FAIL lsu7_wr: got we=%b rd=%0d data=%h busy=%h, want 1 7 00000077 00000004", rf_we, rf_rd, rf_data, rf_busy); end
    endtask

    // last grant is now LSU, so the conflict starts with ALU; reissuing rd=2
    // on each LSU grant keeps busy[2] set for every load return
    task automatic test_round_robin;
        logic exp_alu;
        alu_val = 1; alu_rd = 1; alu_data = 32'h11;
        lsu_val = 1; lsu_rd = 2; lsu_data = 32'h22;
        iss_val = 1; iss_rd = 2;
        for (int k = 0; k < 4; k++) begin
            exp_alu = (k % 2 == 0);
            #1;
            checks++; if ({alu_rdy, lsu_rdy, iss_rdy} !== {exp_alu, !exp_alu, !exp_alu}) begin fails++; $display("FAIL rr_grant%0d: got alu=%b lsu=%b iss=%b, want %b %b %b", k, alu_rdy, lsu_rdy, iss_rdy, exp_alu, !exp_alu, !exp_alu); end
            step();
            checks++; if ({rf_we, rf_rd, rf_data, rf_busy} !== {1'b1, exp_alu ? 5'd1 : 5'd2, exp_alu ? 32'h11 : 32'h22, 32'h4}) begin fails++; $display("FAIL rr_write%0d: got we=%b rd=%0d data=%h busy=%h", k, rf_we, rf_rd, rf_data, rf_busy); end
        end
        alu_val = 0; lsu_val = 0; iss_val = 0;
        step();
    endtask

    task automatic test_fixed_priority;
        f_alu_val = 1; f_alu_rd = 1; f_alu_data = 32'hA1;
        f_lsu_val = 1; f_lsu_rd = 2; f_lsu_data = 32'hB2;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if ({f_alu_rdy, f_lsu_rdy} !== 2'b10) begin fails++; $display("FAIL fp_grant%0d: got alu=%b lsu=%b, want 1 0", k, f_alu_rdy, f_lsu_rdy); end
            step();
            checks++; if ({f_rf_we, f_rf_rd, f_rf_data} !== {1'b1, 5'd1, 32'hA1}) begin fails++; $display("FAIL fp_write%0d: got we=%b rd=%0d data=%h, want 1 1 000000a1", k, f_rf_we, f_rf_rd, f_rf_data); end
        end
        f_alu_val = 0; f_lsu_val = 0;
        step();
    endtask

    task automatic test_same_cycle;
        iss_val = 1; iss_rd = 7;
        step();
        checks++; if (rf_busy !== 32'h84) begin fails++; $display("FAIL reissue7_busy: got %h, want 00000084", rf_busy); end
        lsu_val = 1; lsu_rd = 7; lsu_data = 32'h70;
        #1;
        checks++; if ({lsu_rdy, iss_rdy} !== 2'b11) begin fails++; $display("FAIL same_cycle_rdy: got lsu=%b iss=%b, want 1 1", lsu_rdy, iss_rdy); end
        step();
        lsu_val = 0; iss_val = 0;
        checks++; if ({rf_we, rf_rd, rf_busy} !== {1'b1, 5'd7, 32'h84}) begin fails++; $display("FAIL set_wins: got we=%b rd=%0d busy=%h, want 1 7 00000084", rf_we, rf_rd, rf_busy); end
        alu_val = 1; alu_rd = 0; alu_data = 32'h99;
        #1;
        checks++; if (alu_rdy !== 1'b1) begin fails++; $display("FAIL alu_x0_rdy: got %b, want 1", alu_rdy); end
        step();
        alu_val = 0;
        checks++; if (rf_we !== 1'b0) begin fails++; $display("FAIL alu_x0_we: got %b, want 0", rf_we); end
        lsu_val = 1; lsu_rd = 0; lsu_data = 32'h98;
        #1;
        checks++; if (lsu_rdy !== 1'b1) begin fails++; $display("FAIL lsu_x0_rdy: got %b, want 1", lsu_rdy); end
        step();
        lsu_val = 0;
        checks++; if ({rf_we, rf_busy} !== {1'b0, 32'h84}) begin fails++; $display("FAIL lsu_x0_we: got we=%b busy=%h, want 0 00000084", rf_we, rf_busy); end
    endtask

    task automatic test_async_reset;
        lsu_val = 1; lsu_rd = 2; lsu_data = 32'h2;
        step();
        lsu_val = 0;
        checks++; if ({rf_we, rf_busy} !== {1'b1, 32'h80}) begin fails++; $display("FAIL pre_reset: got we=%b busy=%h, want 1 00000080", rf_we, rf_busy); end
        #2 rst = 1'b1;
        #1;
        checks++; if ({rf_we, rf_rd, rf_data, rf_busy} !== 70'd0) begin fails++; $display("FAIL async_reset: got we=%b rd=%0d data=%h busy=%h, want all 0", rf_we, rf_rd, rf_data, rf_busy); end
        step();
        rst = 1'b0;
        alu_val = 1; alu_rd = 3; alu_data = 32'h33;
        lsu_val = 1; lsu_rd = 0; lsu_data = 32'h44;
        #1;
        checks++; if ({alu_rdy, lsu_rdy} !== 2'b01) begin fails++; $display("FAIL post_reset_grant: got alu=%b lsu=%b, want 0 1", alu_rdy, lsu_rdy); end
        step();
        lsu_val = 0;
        #1;
        checks++; if (alu_rdy !== 1'b1) begin fails++; $display("FAIL post_reset_alu: got %b, want 1", alu_rdy); end
        step();
        alu_val = 0;
        checks++; if ({rf_we, rf_rd, rf_data} !== {1'b1, 5'd3, 32'h33}) begin fails++; $display("FAIL post_reset_wr: got we=%b rd=%0d data=%h, want 1 3 00000033", rf_we, rf_rd, rf_data); end
    endtask

    initial begin
        test_reset();
        test_alu_only();
        test_scoreboard();
        test_round_robin();
        test_fixed_priority();
        test_same_cycle();
        test_async_reset();
        step();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
